cla_pipe_adder: RTL and testbench

CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

---
 rtl/cla_pipe_adder.sv | 176 +++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit CLA groups; one
// segment of WIDTH/STAGES bits resolves per stage, with optional signed saturation.
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             pm,
  output logic             gm
);

  localparam int SEG = WIDTH / STAGES;
  localparam int NG  = SEG / 4;
  localparam int L   = STAGES - 1;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [3:0] cla4_sum(input logic [3:0] x, input logic [3:0] y,
                                          input logic c0);
    logic [3:0] p;
    logic [2:0] g;
    logic [3:0] c;
    p    = x ^ y;
    g    = x[2:0] & y[2:0];
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return p ^ c;
  endfunction

  function automatic logic cla4_gen(input logic [3:0] x, input logic [3:0] y);
    logic [3:1] p;
    logic [3:0] g;
    p = x[3:1] ^ y[3:1];
    g = x & y;
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Stage inputs: stage 0 reads the ports, stage k reads the registers of stage k-1
  logic [STAGES-1:0][WIDTH-1:0] w_a, w_b, w_sum;
  logic [STAGES-1:0]            w_ci, w_p, w_g, w_sat, w_v;
  logic [STAGES-1:0][SEG-1:0]   w_seg_sum;
  logic [STAGES-1:0]            w_seg_co, w_seg_p, w_seg_g;

  logic [STAGES-1:0][WIDTH-1:0] r_a, r_b, r_sum;
  logic [STAGES-1:0]            r_c, r_p, r_g, r_sat, r_valid;

  logic             w_adv;
  logic [WIDTH-1:0] w_raw;
  logic             w_amsb, w_bmsb, w_ovf;
  logic             w_unused;

  genvar gi, gj;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO = gi * SEG;
      logic [NG-1:0] w_gp, w_gg;
      logic [NG:0]   w_gc;
      logic          w_sg;

      if (gi == 0) begin : g_head
        assign w_a[gi]   = a;
        assign w_b[gi]   = sub ? ~b : b;
        assign w_sum[gi] = '0;
        assign w_ci[gi]  = sub | cin;
        assign w_p[gi]   = 1'b1;
        assign w_g[gi]   = 1'b0;
        assign w_sat[gi] = sat;
        assign w_v[gi]   = in_valid;
      end else begin : g_body
        assign w_a[gi]   = r_a[gi-1];
        assign w_b[gi]   = r_b[gi-1];
        assign w_sum[gi] = r_sum[gi-1];
        assign w_ci[gi]  = r_c[gi-1];
        assign w_p[gi]   = r_p[gi-1];
        assign w_g[gi]   = r_g[gi-1];
        assign w_sat[gi] = r_sat[gi-1];
        assign w_v[gi]   = r_valid[gi-1];
      end

      for (gj = 0; gj < NG; gj++) begin : g_grp
        assign w_gp[gj] = &(w_a[gi][LO+gj*4 +: 4] ^ w_b[gi][LO+gj*4 +: 4]);
        assign w_gg[gj] = cla4_gen(w_a[gi][LO+gj*4 +: 4], w_b[gi][LO+gj*4 +: 4]);
        assign w_seg_sum[gi][gj*4 +: 4] =
          cla4_sum(w_a[gi][LO+gj*4 +: 4], w_b[gi][LO+gj*4 +: 4], w_gc[gj]);
      end

      // Lookahead carry unit: each group carry is a flat sum of products, no ripple
      always_comb begin : lcu
        logic gen_acc;
        logic term;
        logic pall;
        gen_acc = 1'b0;
        term    = 1'b0;
        pall    = 1'b0;
        w_gc    = '0;
        w_gc[0] = w_ci[gi];
        for (int j = 0; j < NG; j++) begin
          gen_acc = 1'b0;
          for (int i = 0; i <= j; i++) begin
            term = w_gg[i];
            for (int m = i + 1; m <= j; m++) term = term & w_gp[m];
            gen_acc = gen_acc | term;
          end
          pall = w_ci[gi];
          for (int m = 0; m <= j; m++) pall = pall & w_gp[m];
          w_gc[j+1] = gen_acc | pall;
        end
        w_sg = gen_acc;
      end

      assign w_seg_co[gi] = w_gc[NG];
      assign w_seg_p[gi]  = &w_gp;
      assign w_seg_g[gi]  = w_sg;
    end
  endgenerate

  assign w_adv    = !r_valid[L] | out_ready;
  assign in_ready = w_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= w_v[k];
        r_a[k]     <= w_a[k];
        r_b[k]     <= w_b[k];
        r_sum[k]   <= w_sum[k];
        r_sum[k][k*SEG +: SEG] <= w_seg_sum[k];
        r_c[k]     <= w_seg_co[k];
        r_p[k]     <= w_p[k] & w_seg_p[k];
        r_g[k]     <= w_seg_g[k] | (w_seg_p[k] & w_g[k]);
        r_sat[k]   <= w_sat[k];
      end
    end
  end

  // Only the operand sign bits matter once every segment is resolved
  assign w_unused = ^{r_a[L][WIDTH-2:0], r_b[L][WIDTH-2:0]};

  assign w_raw  = r_sum[L];
  assign w_amsb = r_a[L][WIDTH-1];
  assign w_bmsb = r_b[L][WIDTH-1];
  assign w_ovf  = (w_amsb == w_bmsb) & (w_raw[WIDTH-1] != w_amsb);

  assign out_valid = r_valid[L];

  always_comb begin
    s = '0;
    if (out_valid) begin
      if (r_sat[L] & w_ovf) s = w_amsb ? MIN_NEG : MAX_POS;
      else                  s = w_raw;
    end
  end

  assign cout = out_valid & r_c[L];
  assign ovf  = out_valid & w_ovf;
  assign pm   = out_valid & r_p[L];
  assign gm   = out_valid & r_g[L];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: directed corner cases, stalls, reset flush
// and a randomized stream, each checked against an arithmetic reference.
module tb_cla_pipe_adder;
  localparam int W = 32;
  localparam int S = 2;
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};

  typedef struct {
    logic [W-1:0] s;
    logic cout, ovf, pm, gm;
    int cyc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a, b;
    logic cin, sub, sat;
    logic [W-1:0] s;
    logic cout, ovf, pm, gm;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic cin = 1'b0, sub = 1'b0, sat = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [W-1:0] s;
  logic cout, ovf, pm, gm;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .pm(pm), .gm(gm)
  );

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic tc, input logic tsub, input logic tsat);
    exp_t e;
    logic [W-1:0] be;
    logic [W:0] full, gen;
    logic ov;
    be   = tsub ? ~tb_ : tb_;
    full = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, (tsub | tc)};
    gen  = {1'b0, ta} + {1'b0, be};
    ov   = (ta[W-1] == be[W-1]) && (full[W-1] != ta[W-1]);
    e.s    = (tsat && ov) ? (ta[W-1] ? MINN : MAXP) : full[W-1:0];
    e.cout = full[W];
    e.ovf  = ov;
    e.pm   = &(ta ^ be);
    e.gm   = gen[W];
    e.cyc  = cyc;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] r;
    r = $urandom();
    case ($urandom_range(0, 5))
      0: r = '0;
      1: r = '1;
      2: r = MAXP;
      3: r = MINN;
      default: ;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({out_valid, cout, ovf, pm, gm, in_ready} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_flags: got valid/cout/ovf/pm/gm/in_ready=%b, expected 000001",
               {out_valid, cout, ovf, pm, gm, in_ready});
    end
    n_checks++;
    if (s !== '0) begin
      n_fail++;
      $display("FAIL reset_s: got s=%h, expected 0", s);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_valid: got out_valid=%b, expected 0", out_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_directed();
    vec_t v[9];
    exp_t e;
    int j;
    v[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
    v[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    v[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0};
    v[3] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1};
    v[4] = '{32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    v[5] = '{32'h00000005, 32'h00000003, 1'b0, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b1};
    v[6] = '{32'h00000003, 32'h00000005, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
    v[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1};
    v[8] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1};
    j = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && (j < 9 || sb.size() != 0); c++) begin
      in_valid = (j < 9);
      if (j < 9) begin
        a = v[j].a; b = v[j].b; cin = v[j].cin; sub = v[j].sub; sat = v[j].sat;
      end
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL dir_extra_beat: got s=%h, expected no beat", s);
        end else begin
          e = sb.pop_front();
          if ({s, cout, ovf, pm, gm} !== {e.s, e.cout, e.ovf, e.pm, e.gm}) begin
            n_fail++;
            $display("FAIL dir_result: got s=%h cout=%b ovf=%b pm=%b gm=%b, expected s=%h cout=%b ovf=%b pm=%b gm=%b",
                     s, cout, ovf, pm, gm, e.s, e.cout, e.ovf, e.pm, e.gm);
          end else begin
            $display("dir beat s=%h cout=%b ovf=%b pm=%b gm=%b ok", s, cout, ovf, pm, gm);
          end
          n_checks++;
          if (cyc - e.cyc != S) begin
            n_fail++;
            $display("FAIL dir_latency: got %0d cycles, expected %0d", cyc - e.cyc, S);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back('{v[j].s, v[j].cout, v[j].ovf, v[j].pm, v[j].gm, cyc});
        j++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++;
    if (j != 9 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL dir_drain: got sent=%0d pending=%0d, expected sent=9 pending=0", j, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ba[8], bb[8];
    logic bc[8], bs[8], bt[8];
    exp_t e;
    int j;
    logic exp_rdy, prev_stall;
    logic [W-1:0] prev_s;
    for (int k = 0; k < 8; k++) begin
      ba[k] = rnd_op(); bb[k] = rnd_op();
      bc[k] = 1'($urandom_range(0, 1)); bs[k] = 1'($urandom_range(0, 1));
      bt[k] = 1'($urandom_range(0, 1));
    end
    j = 0;
    prev_stall = 1'b0;
    prev_s = '0;
    for (int i = 0; i < 40 && (j < 8 || sb.size() != 0); i++) begin
      out_ready = !(i >= 3 && i <= 5);
      in_valid = (j < 8);
      if (j < 8) begin
        a = ba[j]; b = bb[j]; cin = bc[j]; sub = bs[j]; sat = bt[j];
      end
      #1;
      exp_rdy = (i >= 3 && i <= 5 && i >= S) ? 1'b0 : 1'b1;
      n_checks++;
      if (in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL b2b_in_ready cycle %0d: got %b, expected %b", i, in_ready, exp_rdy);
      end
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || s !== prev_s) begin
          n_fail++;
          $display("FAIL b2b_stall_hold cycle %0d: got valid=%b s=%h, expected valid=1 s=%h",
                   i, out_valid, s, prev_s);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra_beat: got s=%h, expected no beat", s);
        end else begin
          e = sb.pop_front();
          if ({s, cout, ovf, pm, gm} !== {e.s, e.cout, e.ovf, e.pm, e.gm}) begin
            n_fail++;
            $display("FAIL b2b_result: got s=%h cout=%b ovf=%b pm=%b gm=%b, expected s=%h cout=%b ovf=%b pm=%b gm=%b",
                     s, cout, ovf, pm, gm, e.s, e.cout, e.ovf, e.pm, e.gm);
          end else begin
            $display("b2b beat s=%h cout=%b ovf=%b ok", s, cout, ovf);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_s = s;
      if (in_valid && in_ready) begin
        sb.push_back(model(a, b, cin, sub, sat));
        j++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (j != 8 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: got sent=%0d pending=%0d, expected sent=8 pending=0", j, sb.size());
    end
  endtask

  task automatic test_reset_flush();
    exp_t e;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = rnd_op(); b = rnd_op(); cin = 1'b0; sub = 1'b0; sat = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    n_checks++;
    if ({out_valid, cout, ovf, pm, gm, in_ready} !== 6'b000001 || s !== '0) begin
      n_fail++;
      $display("FAIL flush_after_rst: got valid/cout/ovf/pm/gm/in_ready=%b s=%h, expected 000001 s=0",
               {out_valid, cout, ovf, pm, gm, in_ready}, s);
    end
    out_ready = 1'b1;
    for (int i = 0; i < S + 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_stale_beat cycle %0d: got out_valid=%b s=%h, expected 0", i, out_valid, s);
      end
      @(negedge clk);
    end
    in_valid = 1'b1; a = 32'h12345678; b = 32'h0FEDCBA9; cin = 1'b1; sub = 1'b0; sat = 1'b0;
    e = model(a, b, cin, sub, sat);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != S) begin
      n_fail++;
      $display("FAIL flush_latency: got %0d cycles, expected %0d", lat, S);
    end
    n_checks++;
    if ({s, cout, ovf, pm, gm} !== {e.s, e.cout, e.ovf, e.pm, e.gm}) begin
      n_fail++;
      $display("FAIL flush_result: got s=%h cout=%b ovf=%b, expected s=%h cout=%b ovf=%b",
               s, cout, ovf, e.s, e.cout, e.ovf);
    end else begin
      $display("flush beat s=%h latency=%0d ok", s, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    exp_t e;
    int j;
    logic prev_stall;
    logic [W-1:0] prev_s;
    j = 0;
    prev_stall = 1'b0;
    prev_s = '0;
    for (int c = 0; c < 20000 && (j < 400 || sb.size() != 0); c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = (j < 400) && ($urandom_range(0, 4) != 0);
      a = rnd_op(); b = rnd_op();
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1)); sat = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || s !== prev_s) begin
          n_fail++;
          $display("FAIL rnd_stall_hold: got valid=%b s=%h, expected valid=1 s=%h", out_valid, s, prev_s);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_extra_beat: got s=%h, expected no beat", s);
        end else begin
          e = sb.pop_front();
          if ({s, cout, ovf, pm, gm} !== {e.s, e.cout, e.ovf, e.pm, e.gm}) begin
            n_fail++;
            $display("FAIL rnd_result: got s=%h cout=%b ovf=%b pm=%b gm=%b, expected s=%h cout=%b ovf=%b pm=%b gm=%b",
                     s, cout, ovf, pm, gm, e.s, e.cout, e.ovf, e.pm, e.gm);
          end else begin
            $display("rnd beat s=%h cout=%b ovf=%b pm=%b gm=%b ok", s, cout, ovf, pm, gm);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_s = s;
      if (in_valid && in_ready) begin
        sb.push_back(model(a, b, cin, sub, sat));
        j++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (j != 400 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_drain: got sent=%0d pending=%0d, expected sent=400 pending=0", j, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    n_fail++;
    $display("FAIL global_timeout: got no completion, expected finish within time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
